// File: rtl/logic_acc_unit_pkg.sv
// Shared definitions for logic_acc_unit: gate op codes, FSM state encoding and fold classes.
package logic_acc_unit_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_NOTA = 3'b110;
  localparam logic [2:0] OP_BUFA = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    FOLD_AND  = 2'd0,
    FOLD_OR   = 2'd1,
    FOLD_XOR  = 2'd2,
    FOLD_LAST = 2'd3
  } fold_t;

  // Inverted gates fold with the same operator as their plain counterpart.
  function automatic fold_t fold_kind(input logic [2:0] op);
    case (op)
      OP_AND, OP_NAND: fold_kind = FOLD_AND;
      OP_OR,  OP_NOR:  fold_kind = FOLD_OR;
      OP_XOR, OP_XNOR: fold_kind = FOLD_XOR;
      default:         fold_kind = FOLD_LAST;
    endcase
  endfunction

endpackage

// File: rtl/logic_op_core.sv
// Combinational WIDTH-bit gate: f = op(a, b). No state; usable standalone.
module logic_op_core
  import logic_acc_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] f
);

  always_comb begin
    f = '0;
    case (op)
      OP_AND:  f = a & b;
      OP_OR:   f = a | b;
      OP_XOR:  f = a ^ b;
      OP_NAND: f = ~(a & b);
      OP_NOR:  f = ~(a | b);
      OP_XNOR: f = ~(a ^ b);
      OP_NOTA: f = ~a;
      OP_BUFA: f = a;
      default: f = '0;
    endcase
  end

endmodule

// File: rtl/logic_acc_unit.sv
// Burst gate accumulator: applies a latched gate op per beat and folds the burst into one result.
// Optional o_parity output is enabled by defining LOGIC_ACC_PARITY_EN.
//
// Handshakes: a beat transfers on a rising edge where i_valid && o_ready; a result transfers on a
// rising edge where o_valid && i_ready. A valid side holds its payload stable until it transfers.
module logic_acc_unit
  import logic_acc_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [2:0]       i_op,
  input  logic             i_last,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_y,
  output logic [CNT_W-1:0] o_beats
`ifdef LOGIC_ACC_PARITY_EN
  ,
  output logic             o_parity
`endif
);

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d, op_sel;
  logic [WIDTH-1:0] acc_q, acc_d, f;
  logic [CNT_W-1:0] beats_q, beats_d;
  logic             accept;

  assign o_ready = rst_n && (state_q != ST_DONE);
  assign accept  = i_valid && o_ready;
  // The first beat uses the live op; later beats use the op latched at burst start.
  assign op_sel  = (state_q == ST_IDLE) ? i_op : op_q;

  logic_op_core #(.WIDTH(WIDTH)) u_core (
    .op (op_sel),
    .a  (i_a),
    .b  (i_b),
    .f  (f)
  );

  function automatic logic [WIDTH-1:0] fold(input logic [2:0] op,
                                            input logic [WIDTH-1:0] acc,
                                            input logic [WIDTH-1:0] val);
    case (fold_kind(op))
      FOLD_AND: fold = acc & val;
      FOLD_OR:  fold = acc | val;
      FOLD_XOR: fold = acc ^ val;
      default:  fold = val;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    beats_d = beats_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d    = i_op;
          acc_d   = f;
          beats_d = CNT_W'(1);
          state_d = i_last ? ST_DONE : ST_ACC;
        end
      end
      ST_ACC: begin
        if (accept) begin
          acc_d = fold(op_q, acc_q, f);
          if (beats_q != '1) beats_d = beats_q + CNT_W'(1);
          state_d = i_last ? ST_DONE : ST_ACC;
        end
      end
      ST_DONE: begin
        if (i_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_AND;
      acc_q   <= '0;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      beats_q <= beats_d;
    end
  end

  assign o_valid = (state_q == ST_DONE);
  assign o_y     = acc_q;
  assign o_beats = beats_q;

`ifdef LOGIC_ACC_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk) begin
    if (!rst_n) parity_q <= 1'b0;
    else        parity_q <= ^acc_d;
  end

  assign o_parity = parity_q;
`endif

endmodule

// File: tb/tb_logic_acc_unit.sv
// Testbench for logic_acc_unit: randomized bursts against a reference model, scoreboard monitor.
module tb_logic_acc_unit;

  localparam int W = 8;
  localparam int C = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [W-1:0]  i_a = '0;
  logic [W-1:0]  i_b = '0;
  logic [2:0]    i_op = '0;
  logic          i_last = 1'b0;
  logic          o_valid;
  logic          i_ready = 1'b0;
  logic [W-1:0]  o_y;
  logic [C-1:0]  o_beats;
`ifdef LOGIC_ACC_PARITY_EN
  logic          o_parity;
`endif

  logic_acc_unit #(.WIDTH(W), .CNT_W(C)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_a      (i_a),
    .i_b      (i_b),
    .i_op     (i_op),
    .i_last   (i_last),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_y      (o_y),
    .o_beats  (o_beats)
`ifdef LOGIC_ACC_PARITY_EN
    ,
    .o_parity (o_parity)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] exp_q[$];
  logic [C-1:0] exp_beats_q[$];

  logic [W-1:0] burst_a[0:511];
  logic [W-1:0] burst_b[0:511];

  logic rand_ready  = 1'b0;
  logic ready_force = 1'b0;

  always @(posedge clk) begin
    #1;
    i_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_gate(input logic [2:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    case (op)
      3'd0:    ref_gate = a & b;
      3'd1:    ref_gate = a | b;
      3'd2:    ref_gate = a ^ b;
      3'd3:    ref_gate = ~(a & b);
      3'd4:    ref_gate = ~(a | b);
      3'd5:    ref_gate = ~(a ^ b);
      3'd6:    ref_gate = ~a;
      default: ref_gate = a;
    endcase
  endfunction

  task automatic push_expected(input logic [2:0] op, input int n);
    logic [W-1:0] r;
    logic [W-1:0] v;
    r = ref_gate(op, burst_a[0], burst_b[0]);
    for (int i = 1; i < n; i++) begin
      v = ref_gate(op, burst_a[i], burst_b[i]);
      if (op >= 3'd6)        r = v;
      else if (op % 3 == 0)  r = r & v;
      else if (op % 3 == 1)  r = r | v;
      else                   r = r ^ v;
    end
    exp_q.push_back(r);
    exp_beats_q.push_back((n > 255) ? C'(255) : C'(n));
  endtask

  // ---------------- driver ----------------
  task automatic drive_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [2:0] op, input logic last);
    int   cyc;
    logic took;
    cyc  = 0;
    took = 1'b0;
    i_valid = 1'b1;
    i_a = a;
    i_b = b;
    i_op = op;
    i_last = last;
    while (!took && cyc < 500) begin
      @(negedge clk);
      took = o_ready;
      @(posedge clk);
      #1;
      cyc++;
    end
    i_valid = 1'b0;
    if (!took) begin
      n_cmp++;
      n_err++;
      $display("FAIL beat_accept_timeout: got no accept expected accept at %0t", $time);
    end
  endtask

  // Later beats carry a different op so that op latching is exercised.
  task automatic send_burst(input logic [2:0] op, input int n, input logic gaps);
    push_expected(op, n);
    for (int i = 0; i < n; i++) begin
      drive_beat(burst_a[i], burst_b[i], (i == 0) ? op : (op ^ 3'b001), i == n - 1);
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
      exp_beats_q.delete();
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic         prev_hold = 1'b0;
  logic [W-1:0] prev_y = '0;

  always @(negedge clk) begin
    if (prev_hold) begin
      check("hold_valid", 32'(o_valid), 32'd1);
      check("hold_y", 32'(o_y), 32'(prev_y));
    end
    if (rst_n && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_result: got y=%0h expected no result", o_y);
      end else begin
        check("result_y", 32'(o_y), 32'(exp_q[0]));
        check("result_beats", 32'(o_beats), 32'(exp_beats_q[0]));
`ifdef LOGIC_ACC_PARITY_EN
        check("result_parity", 32'(o_parity), 32'(^exp_q[0]));
`endif
        void'(exp_q.pop_front());
        void'(exp_beats_q.pop_front());
      end
    end
    prev_hold = rst_n && o_valid && !i_ready;
    prev_y    = o_y;
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_valid", 32'(o_valid), 32'd0);
    check("reset_ready", 32'(o_ready), 32'd0);
    check("reset_y", 32'(o_y), 32'd0);
    check("reset_beats", 32'(o_beats), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rand_ready = 1'b1;
    @(negedge clk);
    check("idle_ready", 32'(o_ready), 32'd1);
    @(posedge clk);
    #1;

    // AND single beat
    burst_a[0] = 8'hF0; burst_b[0] = 8'h3C;
    send_burst(3'b000, 1, 1'b0);
    // XOR three beats
    burst_a[0] = 8'hFF; burst_b[0] = 8'h0F;
    burst_a[1] = 8'hAA; burst_b[1] = 8'h00;
    burst_a[2] = 8'h01; burst_b[2] = 8'h00;
    send_burst(3'b010, 3, 1'b0);
    // OR latched, second beat presents AND
    burst_a[0] = 8'h01; burst_b[0] = 8'h02;
    burst_a[1] = 8'h04; burst_b[1] = 8'h00;
    send_burst(3'b001, 2, 1'b1);
    drain();

    // Backpressure: result pending with a beat offered
    rand_ready = 1'b0;
    ready_force = 1'b0;
    @(posedge clk);
    #1;
    burst_a[0] = 8'hF0; burst_b[0] = 8'h3C;
    send_burst(3'b000, 1, 1'b0);
    i_valid = 1'b1; i_a = 8'h11; i_b = 8'h22; i_op = 3'b010; i_last = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_valid", 32'(o_valid), 32'd1);
      check("bp_ready", 32'(o_ready), 32'd0);
      check("bp_y", 32'(o_y), 32'h30);
      @(posedge clk);
      #1;
    end
    burst_a[0] = 8'h11; burst_b[0] = 8'h22;
    push_expected(3'b010, 1);
    ready_force = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_release_valid", 32'(o_valid), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_idle_valid", 32'(o_valid), 32'd0);
    check("bp_idle_ready", 32'(o_ready), 32'd1);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    drain();

    // Reset mid-burst
    rand_ready = 1'b1;
    drive_beat(8'h12, 8'h34, 3'b001, 1'b0);
    drive_beat(8'h56, 8'h78, 3'b001, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_ready", 32'(o_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_valid", 32'(o_valid), 32'd0);
    check("midrst_beats", 32'(o_beats), 32'd0);
    @(posedge clk);
    #1;
    burst_a[0] = 8'hFF; burst_b[0] = 8'h0F;
    send_burst(3'b011, 1, 1'b0);
    drain();

    // Beat counter saturation with BUF A (last beat wins)
    for (int i = 0; i < 300; i++) begin
      burst_a[i] = W'($urandom);
      burst_b[i] = W'($urandom);
    end
    burst_a[299] = 8'h07;
    send_burst(3'b111, 300, 1'b0);
    drain();

    // Randomized bursts
    for (int t = 0; t < 60; t++) begin
      int n;
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        burst_a[i] = W'($urandom);
        burst_b[i] = W'($urandom);
      end
      send_burst(3'($urandom_range(0, 7)), n, 1'($urandom_range(0, 1)));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
